rf_scoreboard: RTL and testbench

//  Decode-stage hazard tracker sitting directly upstream of the 8x16 register file (rf).

---
 rtl/rf_scoreboard_pkg.sv | 19 +
 rtl/rf_scoreboard_sb_counter.sv | 48 ++++
 rtl/rf_scoreboard.sv | 79 +++++++
 tb/tb_rf_scoreboard.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_scoreboard_pkg.sv
// Shared constants, types and select decode for the register-file scoreboard.
package rf_scoreboard_pkg;

    localparam int NREGS         = 8;
    localparam int REG_SEL_W     = 3;
    localparam int CNT_W_DEFAULT = 2;

    typedef logic [REG_SEL_W-1:0] reg_sel_t;
    typedef logic [NREGS-1:0]     reg_vec_t;

    // One-hot decode of a register select, all-zero when not enabled.
    function automatic reg_vec_t sel_decode(input logic en, input reg_sel_t sel);
        reg_vec_t v;
        v = '0;
        if (en) v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rf_scoreboard_sb_counter.sv
// Per-register pending-write counter: one increment and up to two decrements per cycle,
// clamped at both ends with flags reporting when a clamp was needed.
module sb_counter
    import rf_scoreboard_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic [1:0]       dec,
    output logic [CNT_W-1:0] count,
    output logic             underflow,
    output logic             overflow
);

    localparam int                SUM_W   = CNT_W + 2;
    localparam logic [SUM_W-1:0]  CNT_MAX = SUM_W'((1 << CNT_W) - 1);

    logic [CNT_W-1:0] count_reg, count_next;
    logic [SUM_W-1:0] total, dec_ext, diff;

    // Wider arithmetic so a net -2 or a +1 at saturation is visible before clamping.
    always_comb begin
        total      = SUM_W'(count_reg) + SUM_W'(inc);
        dec_ext    = SUM_W'(dec);
        diff       = total - dec_ext;
        underflow  = (total < dec_ext);
        overflow   = !underflow && (diff > CNT_MAX);
        count_next = diff[CNT_W-1:0];
        if (underflow) begin
            count_next = '0;
        end else if (overflow) begin
            count_next = CNT_MAX[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/rf_scoreboard.sv
// Decode-stage hazard tracker: counts in-flight writes per register and stalls issue on
// RAW hazards or when the destination's pending count would saturate.
module rf_scoreboard
    import rf_scoreboard_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid,
    input  logic                 issue_rs1_en,
    input  logic [REG_SEL_W-1:0] issue_rs1,
    input  logic                 issue_rs2_en,
    input  logic [REG_SEL_W-1:0] issue_rs2,
    input  logic                 issue_rd_en,
    input  logic [REG_SEL_W-1:0] issue_rd,
    output logic                 issue_ready,
    input  logic                 wb_valid,
    input  logic [REG_SEL_W-1:0] wb_rd,
    input  logic                 cancel_valid,
    input  logic [REG_SEL_W-1:0] cancel_rd,
    output logic [NREGS-1:0]     busy_vec,
    output logic                 err
);

    localparam int               RES_W   = CNT_W + 2;
    localparam logic [RES_W-1:0] CNT_MAX = RES_W'((1 << CNT_W) - 1);

    reg_vec_t                         wb_hit, cancel_hit, inc_hit;
    reg_vec_t                         underflow_vec, overflow_vec;
    logic [NREGS-1:0][CNT_W-1:0]      count;
    logic [NREGS-1:0][RES_W-1:0]      residual;
    logic                             rs1_hazard, rs2_hazard, rd_hazard, fire;
    logic                             err_reg;

    assign wb_hit     = sel_decode(wb_valid, wb_rd);
    assign cancel_hit = sel_decode(cancel_valid, cancel_rd);
    assign fire       = issue_valid & issue_ready & issue_rd_en;
    assign inc_hit    = sel_decode(fire, issue_rd);

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            logic [1:0] dec_amt;

            assign dec_amt = {1'b0, wb_hit[gi]} + {1'b0, cancel_hit[gi]};
            // Writes retiring this cycle are already visible through rf write-through.
            assign residual[gi] = (RES_W'(count[gi]) > RES_W'(dec_amt))
                                ? RES_W'(count[gi]) - RES_W'(dec_amt) : '0;

            sb_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk       (clk),
                .rst_n     (rst_n),
                .inc       (inc_hit[gi]),
                .dec       (dec_amt),
                .count     (count[gi]),
                .underflow (underflow_vec[gi]),
                .overflow  (overflow_vec[gi])
            );

            assign busy_vec[gi] = |count[gi];
        end
    endgenerate

    assign rs1_hazard  = issue_rs1_en & (residual[issue_rs1] != '0);
    assign rs2_hazard  = issue_rs2_en & (residual[issue_rs2] != '0);
    assign rd_hazard   = issue_rd_en  & (residual[issue_rd] == CNT_MAX);
    assign issue_ready = !(rs1_hazard | rs2_hazard | rd_hazard);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (|(underflow_vec | overflow_vec)) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Scenario tasks plus randomized traffic against an integer pending-count model.
module tb_rf_scoreboard;

    localparam int MAXC = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       issue_valid, issue_rs1_en, issue_rs2_en, issue_rd_en;
    logic [2:0] issue_rs1, issue_rs2, issue_rd;
    logic       issue_ready;
    logic       wb_valid, cancel_valid;
    logic [2:0] wb_rd, cancel_rd;
    logic [7:0] busy_vec;
    logic       err;

    int errors = 0;
    int checks = 0;
    int cnt[8];
    bit m_err;

    always #5 clk = ~clk;

    rf_scoreboard #(.CNT_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_rs1_en (issue_rs1_en),
        .issue_rs1    (issue_rs1),
        .issue_rs2_en (issue_rs2_en),
        .issue_rs2    (issue_rs2),
        .issue_rd_en  (issue_rd_en),
        .issue_rd     (issue_rd),
        .issue_ready  (issue_ready),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .cancel_valid (cancel_valid),
        .cancel_rd    (cancel_rd),
        .busy_vec     (busy_vec),
        .err          (err)
    );

    task automatic set_in(input bit iv, input bit r1e, input int r1, input bit r2e, input int r2,
                          input bit rde, input int rd, input bit wv, input int wr,
                          input bit cv, input int cr);
        issue_valid  = iv;
        issue_rs1_en = r1e;
        issue_rs1    = 3'(r1);
        issue_rs2_en = r2e;
        issue_rs2    = 3'(r2);
        issue_rd_en  = rde;
        issue_rd     = 3'(rd);
        wb_valid     = wv;
        wb_rd        = 3'(wr);
        cancel_valid = cv;
        cancel_rd    = 3'(cr);
        #1;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic int decof(input int r);
        int d;
        d = 0;
        if (wb_valid && int'(wb_rd) == r) d++;
        if (cancel_valid && int'(cancel_rd) == r) d++;
        return d;
    endfunction

    function automatic bit model_ready();
        if (issue_rs1_en && cnt[issue_rs1] - decof(int'(issue_rs1)) > 0) return 1'b0;
        if (issue_rs2_en && cnt[issue_rs2] - decof(int'(issue_rs2)) > 0) return 1'b0;
        if (issue_rd_en && cnt[issue_rd] - decof(int'(issue_rd)) == MAXC) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [7:0] model_busy();
        logic [7:0] b;
        for (int r = 0; r < 8; r++) b[r] = (cnt[r] != 0);
        return b;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 8; r++) cnt[r] = 0;
        m_err = 1'b0;
    endtask

    // Clocks the DUT once and applies the same cycle to the model.
    task automatic advance();
        int nxt[8];
        bit fire;
        fire = issue_valid && issue_rd_en && model_ready();
        for (int r = 0; r < 8; r++) begin
            int v;
            v = cnt[r] - decof(r) + ((fire && int'(issue_rd) == r) ? 1 : 0);
            if (v < 0) begin v = 0; m_err = 1'b1; end
            if (v > MAXC) begin v = MAXC; m_err = 1'b1; end
            nxt[r] = v;
        end
        @(posedge clk);
        for (int r = 0; r < 8; r++) cnt[r] = nxt[r];
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_in(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        advance();
        set_in(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
        advance();
        checks++;
        if (busy_vec !== 8'h0A) begin
            errors++; $display("FAIL reset_pre_busy: busy_vec=%h expected=0a", busy_vec);
        end
        set_in(1, 1, 1, 0, 0, 1, 3, 0, 0, 0, 0);
        checks++;
        if (issue_ready !== 1'b0) begin
            errors++; $display("FAIL reset_pre_stall: ready=%b expected=0", issue_ready);
        end
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if (busy_vec !== 8'h00) begin
            errors++; $display("FAIL reset_busy: busy_vec=%h expected=00", busy_vec);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL reset_err: err=%b expected=0", err);
        end
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: ready=%b expected=1", issue_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        checks++;
        if (busy_vec !== 8'h00) begin
            errors++; $display("FAIL reset_release_busy: busy_vec=%h expected=00", busy_vec);
        end
        $display("txn reset: busy_vec=%h err=%b", busy_vec, err);
    endtask

    task automatic test_raw();
        set_in(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++; $display("FAIL raw_issue: ready=%b expected=1", issue_ready);
        end
        advance();
        checks++;
        if (busy_vec !== 8'h04) begin
            errors++; $display("FAIL raw_busy: busy_vec=%h expected=04", busy_vec);
        end
        set_in(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (issue_ready !== 1'b0) begin
            errors++; $display("FAIL raw_rs1_stall: ready=%b expected=0", issue_ready);
        end
        advance();
        set_in(1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0);
        checks++;
        if (issue_ready !== 1'b0) begin
            errors++; $display("FAIL raw_rs2_stall: ready=%b expected=0", issue_ready);
        end
        advance();
        set_in(1, 1, 2, 0, 0, 0, 0, 1, 2, 0, 0);
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++; $display("FAIL raw_wb_bypass: ready=%b expected=1", issue_ready);
        end
        advance();
        checks++;
        if (busy_vec !== 8'h00) begin
            errors++; $display("FAIL raw_clear: busy_vec=%h expected=00", busy_vec);
        end
        $display("txn raw: busy_vec=%h", busy_vec);
    endtask

    task automatic test_multi_write();
        for (int k = 0; k < 3; k++) begin
            set_in(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
            checks++;
            if (issue_ready !== 1'b1) begin
                errors++; $display("FAIL multi_issue%0d: ready=%b expected=1", k, issue_ready);
            end
            advance();
        end
        checks++;
        if (busy_vec !== 8'h20) begin
            errors++; $display("FAIL multi_busy: busy_vec=%h expected=20", busy_vec);
        end
        set_in(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
        checks++;
        if (issue_ready !== 1'b0) begin
            errors++; $display("FAIL multi_sat_stall: ready=%b expected=0", issue_ready);
        end
        advance();
        set_in(1, 0, 0, 0, 0, 1, 5, 1, 5, 0, 0);
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++; $display("FAIL multi_sat_wb: ready=%b expected=1", issue_ready);
        end
        advance();
        for (int k = 0; k < 3; k++) begin
            set_in(1, 1, 5, 0, 0, 0, 0, 1, 5, 0, 0);
            checks++;
            if (issue_ready !== (k == 2)) begin
                errors++; $display("FAIL multi_raw%0d: ready=%b expected=%b", k, issue_ready, (k == 2));
            end
            advance();
        end
        checks++;
        if (busy_vec !== 8'h00 || err !== 1'b0) begin
            errors++; $display("FAIL multi_drain: busy_vec=%h err=%b expected=00/0", busy_vec, err);
        end
        $display("txn multi_write: busy_vec=%h", busy_vec);
    endtask

    task automatic test_simultaneous();
        set_in(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0);
        advance();
        set_in(1, 0, 0, 0, 0, 1, 4, 1, 4, 0, 0);
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++; $display("FAIL simul_ready: ready=%b expected=1", issue_ready);
        end
        advance();
        checks++;
        if (busy_vec !== 8'h10) begin
            errors++; $display("FAIL simul_busy: busy_vec=%h expected=10", busy_vec);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0);
        advance();
        checks++;
        if (busy_vec !== 8'h00 || err !== 1'b0) begin
            errors++; $display("FAIL simul_net_zero: busy_vec=%h err=%b expected=00/0", busy_vec, err);
        end
        $display("txn simultaneous: busy_vec=%h", busy_vec);
    endtask

    task automatic test_cancel();
        set_in(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
        advance();
        checks++;
        if (busy_vec !== 8'h80) begin
            errors++; $display("FAIL cancel_busy: busy_vec=%h expected=80", busy_vec);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
        advance();
        checks++;
        if (busy_vec !== 8'h00 || err !== 1'b0) begin
            errors++; $display("FAIL cancel_clear: busy_vec=%h err=%b expected=00/0", busy_vec, err);
        end
        set_in(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
        advance();
        set_in(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
        advance();
        set_in(1, 1, 7, 0, 0, 0, 0, 1, 7, 1, 7);
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++; $display("FAIL cancel_dual_ready: ready=%b expected=1", issue_ready);
        end
        advance();
        checks++;
        if (busy_vec !== 8'h00 || err !== 1'b0) begin
            errors++; $display("FAIL cancel_dual_clear: busy_vec=%h err=%b expected=00/0", busy_vec, err);
        end
        $display("txn cancel: busy_vec=%h err=%b", busy_vec, err);
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            bit iv, r1e, r2e, rde, wv, cv;
            int r1, r2, rd, wr, cr, wdec;
            bit exp_ready;
            iv  = ($urandom_range(0, 3) != 0);
            r1e = $urandom_range(0, 1) != 0;
            r2e = $urandom_range(0, 2) == 0;
            rde = $urandom_range(0, 3) != 0;
            r1  = $urandom_range(0, 7);
            r2  = $urandom_range(0, 7);
            rd  = $urandom_range(0, 7);
            wr  = $urandom_range(0, 7);
            cr  = $urandom_range(0, 7);
            wv  = (cnt[wr] > 0) && ($urandom_range(0, 2) != 0);
            wdec = (wv && wr == cr) ? 1 : 0;
            cv  = (cnt[cr] - wdec > 0) && ($urandom_range(0, 3) == 0);
            set_in(iv, r1e, r1, r2e, r2, rde, rd, wv, wr, cv, cr);
            exp_ready = model_ready();
            checks++;
            if (issue_ready !== exp_ready) begin
                errors++; $display("FAIL rand_ready[%0d]: ready=%b expected=%b", n, issue_ready, exp_ready);
            end
            advance();
            checks++;
            if (busy_vec !== model_busy()) begin
                errors++; $display("FAIL rand_busy[%0d]: busy_vec=%h expected=%h", n, busy_vec, model_busy());
            end
            checks++;
            if (err !== m_err) begin
                errors++; $display("FAIL rand_err[%0d]: err=%b expected=%b", n, err, m_err);
            end
            $display("txn rand %0d: iv=%b rd=%0d/%b wb=%b/%0d cx=%b/%0d ready=%b busy=%h",
                     n, iv, rd, rde, wv, wr, cv, cr, issue_ready, busy_vec);
        end
    endtask

    task automatic test_underflow();
        pulse_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0);
        advance();
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL underflow_set: err=%b expected=1", err);
        end
        checks++;
        if (busy_vec !== 8'h00) begin
            errors++; $display("FAIL underflow_count: busy_vec=%h expected=00", busy_vec);
        end
        idle();
        for (int k = 0; k < 3; k++) begin
            advance();
            checks++;
            if (err !== 1'b1) begin
                errors++; $display("FAIL underflow_sticky%0d: err=%b expected=1", k, err);
            end
        end
        pulse_reset();
        idle();
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL underflow_reset: err=%b expected=0", err);
        end
        $display("txn underflow: err=%b", err);
    endtask

    initial begin
        model_clear();
        issue_valid = 0; issue_rs1_en = 0; issue_rs1 = 0; issue_rs2_en = 0; issue_rs2 = 0;
        issue_rd_en = 0; issue_rd = 0; wb_valid = 0; wb_rd = 0; cancel_valid = 0; cancel_rd = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_raw();
        test_multi_write();
        test_simultaneous();
        test_cancel();
        test_random();
        test_underflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit=200000");
        $fatal(1, "timeout");
    end

endmodule
